dcache_load_port_arbiter: RTL and testbench

Shares one data-cache load port between the CPU load unit and the stride prefetcher. Arbitrates the index phase every cycle with CPU priority and a bounded starvation guard for the prefetcher, and steers the following tag phase from the previous cycle's winner. Routes `data_gnt` to the current winner and `data_rvalid`/`data_rdata` to the owner of the oldest outstanding read. Sits between the load unit / prefetcher and the write-through dcache request port.

---
 rtl/dcache_load_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dcache_load_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_load_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_load_port_arbiter                                                 |
// | Shares one dcache load port between the CPU load unit and the prefetcher.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package dcache_lpa_pkg;
    typedef struct packed {
        logic [11:0] address_index;
        logic [19:0] address_tag;
        logic [31:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [3:0]  data_be;
        logic [1:0]  data_size;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [31:0] data_rdata;
    } dcache_req_o_t;
endpackage

module dcache_load_port_arbiter
    import dcache_lpa_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int PfStarveLimit  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  dcache_req_i_t cpu_req_i,
    output dcache_req_o_t cpu_rsp_o,
    input  dcache_req_i_t pf_req_i,
    output dcache_req_o_t pf_rsp_o,
    output dcache_req_i_t cache_req_o,
    input  dcache_req_o_t cache_rsp_i,
    input  logic          pf_enable_i,
    output logic [15:0]   pf_grant_cnt_o,
    output logic          proto_err_o
);
    localparam int c_ptr_w = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int c_cnt_w = $clog2(MaxOutstanding + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt      = c_cnt_w'(MaxOutstanding);
    localparam logic [c_ptr_w-1:0] c_last_ptr     = c_ptr_w'(MaxOutstanding - 1);
    localparam logic [15:0]        c_starve_limit = 16'(PfStarveLimit);
    localparam bit                 c_guard_on     = (PfStarveLimit != 0);

    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_cpu  = 2'd1;
    localparam logic [1:0] c_own_pf   = 2'd2;

    // Each FIFO entry records the owner of an outstanding read: 1 = prefetcher.
    logic               fifo_q [MaxOutstanding];
    logic               fifo_d [MaxOutstanding];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [1:0]         tag_owner_q, tag_owner_d;
    logic [15:0]        starve_q, starve_d;
    logic [15:0]        pf_cnt_q, pf_cnt_d;
    logic               err_q, err_d;

    logic       w_pop, w_full, w_pf_cand, w_gnt, w_pf_gnt;
    logic [1:0] w_winner;
    logic       w_unused_pf;

    assign w_unused_pf = ^{pf_req_i.data_we, pf_req_i.data_wdata};

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_pop     = cache_rsp_i.data_rvalid && (cnt_q != '0);
        w_full    = (cnt_q == c_max_cnt);
        w_pf_cand = pf_req_i.data_req && pf_enable_i;
        w_winner  = c_own_none;
        // A pop in the same cycle frees a slot, so a full FIFO may still grant.
        if (!(w_full && !w_pop)) begin
            if (c_guard_on && (starve_q >= c_starve_limit) && w_pf_cand) begin
                w_winner = c_own_pf;
            end else if (cpu_req_i.data_req) begin
                w_winner = c_own_cpu;
            end else if (w_pf_cand) begin
                w_winner = c_own_pf;
            end
        end
        w_gnt    = (w_winner != c_own_none) && cache_rsp_i.data_gnt;
        w_pf_gnt = w_gnt && (w_winner == c_own_pf);
    end

    always_comb begin
        cache_req_o = '0;
        if (w_winner == c_own_cpu) begin
            cache_req_o.data_req      = 1'b1;
            cache_req_o.address_index = cpu_req_i.address_index;
            cache_req_o.data_wdata    = cpu_req_i.data_wdata;
            cache_req_o.data_be       = cpu_req_i.data_be;
            cache_req_o.data_size     = cpu_req_i.data_size;
            cache_req_o.data_we       = cpu_req_i.data_we;
        end else if (w_winner == c_own_pf) begin
            cache_req_o.data_req      = 1'b1;
            cache_req_o.address_index = pf_req_i.address_index;
            cache_req_o.data_be       = pf_req_i.data_be;
            cache_req_o.data_size     = pf_req_i.data_size;
        end
        if (tag_owner_q == c_own_cpu) begin
            cache_req_o.tag_valid   = cpu_req_i.tag_valid;
            cache_req_o.address_tag = cpu_req_i.address_tag;
            cache_req_o.kill_req    = cpu_req_i.kill_req;
        end else if (tag_owner_q == c_own_pf) begin
            cache_req_o.tag_valid   = pf_req_i.tag_valid;
            cache_req_o.address_tag = pf_req_i.address_tag;
            cache_req_o.kill_req    = pf_req_i.kill_req;
        end
    end

    always_comb begin
        cpu_rsp_o          = '0;
        pf_rsp_o           = '0;
        cpu_rsp_o.data_gnt = w_gnt && (w_winner == c_own_cpu);
        pf_rsp_o.data_gnt  = w_pf_gnt;
        if (w_pop) begin
            if (fifo_q[rd_ptr_q]) begin
                pf_rsp_o.data_rvalid = 1'b1;
                pf_rsp_o.data_rdata  = cache_rsp_i.data_rdata;
            end else begin
                cpu_rsp_o.data_rvalid = 1'b1;
                cpu_rsp_o.data_rdata  = cache_rsp_i.data_rdata;
            end
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_gnt) begin
            fifo_d[wr_ptr_q] = (w_winner == c_own_pf);
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (w_gnt && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (w_pop && !w_gnt) begin
            cnt_d = cnt_q - 1'b1;
        end
        tag_owner_d = w_gnt ? w_winner : c_own_none;
        if (w_pf_cand && !w_pf_gnt) begin
            starve_d = (starve_q == 16'hFFFF) ? starve_q : starve_q + 16'd1;
        end else begin
            starve_d = '0;
        end
        pf_cnt_d = (w_pf_gnt && (pf_cnt_q != 16'hFFFF)) ? pf_cnt_q + 16'd1 : pf_cnt_q;
        err_d    = err_q || (cache_rsp_i.data_rvalid && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q      <= '{default: 1'b0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            tag_owner_q <= c_own_none;
            starve_q    <= '0;
            pf_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            tag_owner_q <= tag_owner_d;
            starve_q    <= starve_d;
            pf_cnt_q    <= pf_cnt_d;
            err_q       <= err_d;
        end
    end

    assign pf_grant_cnt_o = pf_cnt_q;
    assign proto_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_load_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dcache_load_port_arbiter                                              |
// | Vector table, directed corner sequences and randomized model comparison. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dcache_load_port_arbiter;
    import dcache_lpa_pkg::*;

    localparam int MAXO  = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    dcache_req_i_t cpu_req, pf_req, cache_req;
    dcache_req_o_t cpu_rsp, pf_rsp, cache_rsp;
    logic          pf_en;
    logic [15:0]   pf_cnt;
    logic          perr;

    dcache_load_port_arbiter #(.MaxOutstanding(MAXO), .PfStarveLimit(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_i      (cpu_req),
        .cpu_rsp_o      (cpu_rsp),
        .pf_req_i       (pf_req),
        .pf_rsp_o       (pf_rsp),
        .cache_req_o    (cache_req),
        .cache_rsp_i    (cache_rsp),
        .pf_enable_i    (pf_en),
        .pf_grant_cnt_o (pf_cnt),
        .proto_err_o    (perr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner queue (1 = PF), tag owner 0/1/2, counters.
    bit m_q[$];
    int m_tag, m_starve, m_pfcnt, m_win;
    bit m_err, m_gnt, m_pop;
    bit auto_rv;
    dcache_req_i_t e_cache, s_cache;
    dcache_req_o_t e_cpu, e_pf, s_cpu, s_pf;
    logic [15:0]   s_cnt;
    logic          s_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_check();
        int sz = m_q.size();
        m_pop = cache_rsp.data_rvalid && (sz > 0);
        m_win = 0;
        if (!(sz == MAXO && !m_pop)) begin
            if (LIMIT != 0 && m_starve >= LIMIT && pf_req.data_req && pf_en) m_win = 2;
            else if (cpu_req.data_req) m_win = 1;
            else if (pf_req.data_req && pf_en) m_win = 2;
        end
        m_gnt   = (m_win != 0) && cache_rsp.data_gnt;
        e_cache = '0;
        if (m_win == 1) begin
            e_cache.data_req = 1'b1;  e_cache.address_index = cpu_req.address_index;
            e_cache.data_wdata = cpu_req.data_wdata;  e_cache.data_we = cpu_req.data_we;
            e_cache.data_be = cpu_req.data_be;  e_cache.data_size = cpu_req.data_size;
        end else if (m_win == 2) begin
            e_cache.data_req = 1'b1;  e_cache.address_index = pf_req.address_index;
            e_cache.data_be = pf_req.data_be;  e_cache.data_size = pf_req.data_size;
        end
        if (m_tag == 1) begin
            e_cache.tag_valid = cpu_req.tag_valid;  e_cache.address_tag = cpu_req.address_tag;
            e_cache.kill_req = cpu_req.kill_req;
        end else if (m_tag == 2) begin
            e_cache.tag_valid = pf_req.tag_valid;  e_cache.address_tag = pf_req.address_tag;
            e_cache.kill_req = pf_req.kill_req;
        end
        e_cpu = '0;
        e_pf  = '0;
        e_cpu.data_gnt = m_gnt && m_win == 1;
        e_pf.data_gnt  = m_gnt && m_win == 2;
        if (m_pop) begin
            if (m_q[0]) begin e_pf.data_rvalid = 1'b1;  e_pf.data_rdata = cache_rsp.data_rdata; end
            else begin e_cpu.data_rvalid = 1'b1;  e_cpu.data_rdata = cache_rsp.data_rdata; end
        end
        chk("cache_req", 128'(cache_req), 128'(e_cache));
        chk("cpu_rsp", 128'(cpu_rsp), 128'(e_cpu));
        chk("pf_rsp", 128'(pf_rsp), 128'(e_pf));
        chk("pf_grant_cnt", 128'(pf_cnt), 128'(m_pfcnt));
        chk("proto_err", 128'(perr), 128'(m_err));
    endtask

    task automatic model_update();
        if (m_pop) void'(m_q.pop_front());
        else if (cache_rsp.data_rvalid) m_err = 1'b1;
        if (m_gnt) m_q.push_back(m_win == 2);
        m_tag = m_gnt ? m_win : 0;
        if (pf_req.data_req && pf_en && !(m_gnt && m_win == 2))
            m_starve = (m_starve < 65535) ? m_starve + 1 : m_starve;
        else
            m_starve = 0;
        if (m_gnt && m_win == 2 && m_pfcnt < 65535) m_pfcnt++;
    endtask

    task automatic cycle();
        if (auto_rv) begin
            cache_rsp.data_rvalid = (m_q.size() > 0);
            cache_rsp.data_rdata  = $urandom;
        end
        @(negedge clk);
        model_check();
        s_cache = cache_req;  s_cpu = cpu_rsp;  s_pf = pf_rsp;  s_cnt = pf_cnt;  s_err = perr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;  cpu_req = '0;  pf_req = '0;  cache_rsp = '0;  pf_en = 1'b0;  auto_rv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();  m_tag = 0;  m_starve = 0;  m_pfcnt = 0;  m_err = 1'b0;
    endtask

    function automatic dcache_req_i_t rand_req(input int req_pct);
        dcache_req_i_t r;
        r.address_index = 12'($urandom);  r.address_tag = 20'($urandom);
        r.data_wdata = $urandom;  r.data_we = 1'($urandom);  r.data_be = 4'($urandom);
        r.data_size = 2'($urandom);  r.kill_req = ($urandom_range(7, 0) == 0);
        r.tag_valid = 1'($urandom);  r.data_req = ($urandom_range(99, 0) < req_pct);
        return r;
    endfunction

    typedef struct {
        bit cpu_r; logic [11:0] cpu_idx; bit cpu_we; logic [31:0] cpu_wd;
        bit pf_r;  logic [11:0] pf_idx;  bit pf_en;  bit pf_we; logic [31:0] pf_wd; bit gnt;
        bit e_req; logic [11:0] e_idx;   bit e_we;   logic [31:0] e_wd; bit e_cg; bit e_pg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 12'h000, 0, 32'h0,    0, 12'h000, 0, 0, 32'h0,    0,  0, 12'h000, 0, 32'h0,    0, 0};
        vecs[1] = '{1, 12'h010, 0, 32'h0,    0, 12'h000, 0, 0, 32'h0,    1,  1, 12'h010, 0, 32'h0,    1, 0};
        vecs[2] = '{1, 12'h0A5, 1, 32'h1234, 0, 12'h000, 1, 0, 32'h0,    1,  1, 12'h0A5, 1, 32'h1234, 1, 0};
        vecs[3] = '{0, 12'h000, 0, 32'h0,    1, 12'h020, 1, 0, 32'h0,    1,  1, 12'h020, 0, 32'h0,    0, 1};
        vecs[4] = '{0, 12'h000, 0, 32'h0,    1, 12'h021, 1, 1, 32'hDEAD, 1,  1, 12'h021, 0, 32'h0,    0, 1};
        vecs[5] = '{0, 12'h000, 0, 32'h0,    1, 12'h022, 0, 0, 32'h0,    1,  0, 12'h000, 0, 32'h0,    0, 0};
        vecs[6] = '{1, 12'h033, 0, 32'h0,    1, 12'h044, 1, 0, 32'h0,    1,  1, 12'h033, 0, 32'h0,    1, 0};
        vecs[7] = '{1, 12'h055, 0, 32'h0,    0, 12'h000, 1, 0, 32'h0,    0,  1, 12'h055, 0, 32'h0,    0, 0};

        // Reset state with idle inputs.
        reset_dut();
        @(negedge clk);
        chk("reset_cache_req", 128'(cache_req), 128'(0));
        chk("reset_cpu_rsp", 128'(cpu_rsp), 128'(0));
        chk("reset_pf_rsp", 128'(pf_rsp), 128'(0));
        chk("reset_pf_cnt", 128'(pf_cnt), 128'(0));
        chk("reset_proto_err", 128'(perr), 128'(0));

        foreach (vecs[i]) begin
            reset_dut();
            cpu_req.data_req = vecs[i].cpu_r;  cpu_req.address_index = vecs[i].cpu_idx;
            cpu_req.data_we = vecs[i].cpu_we;  cpu_req.data_wdata = vecs[i].cpu_wd;
            pf_req.data_req = vecs[i].pf_r;    pf_req.address_index = vecs[i].pf_idx;
            pf_req.data_we = vecs[i].pf_we;    pf_req.data_wdata = vecs[i].pf_wd;
            pf_en = vecs[i].pf_en;             cache_rsp.data_gnt = vecs[i].gnt;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 128'(cache_req.data_req), 128'(vecs[i].e_req));
            chk($sformatf("vec%0d_idx", i), 128'(cache_req.address_index), 128'(vecs[i].e_idx));
            chk($sformatf("vec%0d_we", i), 128'(cache_req.data_we), 128'(vecs[i].e_we));
            chk($sformatf("vec%0d_wdata", i), 128'(cache_req.data_wdata), 128'(vecs[i].e_wd));
            chk($sformatf("vec%0d_cpu_gnt", i), 128'(cpu_rsp.data_gnt), 128'(vecs[i].e_cg));
            chk($sformatf("vec%0d_pf_gnt", i), 128'(pf_rsp.data_gnt), 128'(vecs[i].e_pg));
        end

        // CPU-only back-to-back reads 0x10..0x12, response one cycle after each grant.
        begin
            int n_rv = 0;
            reset_dut();
            cache_rsp.data_gnt = 1'b1;
            for (int c = 0; c < 5; c++) begin
                cpu_req.data_req      = (c < 3);
                cpu_req.address_index = 12'h010 + 12'(c);
                cpu_req.tag_valid     = (c >= 1 && c <= 3);
                cpu_req.address_tag   = 20'h00100 + 20'(c - 1);
                cache_rsp.data_rvalid = (c >= 1 && c <= 3);
                cache_rsp.data_rdata  = 32'hA000_0000 + 32'(c);
                cycle();
                if (c >= 1 && c <= 3) begin
                    chk("b2b_tag_valid", 128'(s_cache.tag_valid), 128'(1));
                    chk("b2b_tag", 128'(s_cache.address_tag), 128'(20'h00100 + 20'(c - 1)));
                    chk("b2b_rdata", 128'(s_cpu.data_rdata), 128'(32'hA000_0000 + 32'(c)));
                end
                if (s_cpu.data_rvalid) n_rv++;
                chk("b2b_pf_rsp", 128'(s_pf), 128'(0));
            end
            chk("b2b_rvalid_count", 128'(n_rv), 128'(3));
        end

        // Continuous contention with a starve limit of 4.
        reset_dut();
        cpu_req.data_req = 1'b1;  cpu_req.address_index = 12'h030;
        pf_req.data_req = 1'b1;   pf_req.address_index = 12'h040;  pf_en = 1'b1;
        cache_rsp.data_gnt = 1'b1;  auto_rv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk($sformatf("starve_pf_gnt_c%0d", c), 128'(s_pf.data_gnt), 128'(c == 4 || c == 9));
            chk($sformatf("starve_cpu_gnt_c%0d", c), 128'(s_cpu.data_gnt), 128'(!(c == 4 || c == 9)));
            if (c == 5) chk("starve_pf_cnt", 128'(s_cnt), 128'(1));
        end

        // Interleaved CPU, PF, CPU with delayed responses and a full FIFO.
        reset_dut();
        cache_rsp.data_gnt = 1'b1;
        cpu_req.data_req = 1'b1;  cpu_req.address_index = 12'h001;  pf_en = 1'b1;
        cycle();
        chk("il_g1_cpu", 128'(s_cpu.data_gnt), 128'(1));
        cpu_req.data_req = 1'b0;  cpu_req.tag_valid = 1'b1;  cpu_req.address_tag = 20'h000C1;
        pf_req.data_req = 1'b1;   pf_req.address_index = 12'h002;
        cycle();
        chk("il_g2_pf", 128'(s_pf.data_gnt), 128'(1));
        chk("il_cpu_tag", 128'(s_cache.address_tag), 128'(20'h000C1));
        pf_req.data_req = 1'b0;   pf_req.tag_valid = 1'b1;  pf_req.address_tag = 20'h000F2;
        cpu_req.tag_valid = 1'b0; cpu_req.data_req = 1'b1;  cpu_req.address_index = 12'h003;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("il_blocked_req", 128'(s_cache.data_req), 128'(0));
            chk("il_blocked_gnt", 128'(s_cpu.data_gnt), 128'(0));
            pf_req.tag_valid = 1'b0;
        end
        cache_rsp.data_rvalid = 1'b1;  cache_rsp.data_rdata = 32'h111;
        cycle();
        chk("il_rsp1_cpu", 128'(s_cpu.data_rvalid), 128'(1));
        chk("il_g3_on_pop", 128'(s_cpu.data_gnt), 128'(1));
        cpu_req.data_req = 1'b0;  cpu_req.tag_valid = 1'b1;  cpu_req.address_tag = 20'h000C3;
        cache_rsp.data_rdata = 32'h222;
        cycle();
        chk("il_rsp2_pf", 128'(s_pf.data_rvalid), 128'(1));
        chk("il_rsp2_pf_data", 128'(s_pf.data_rdata), 128'(32'h222));
        cpu_req.tag_valid = 1'b0;  cache_rsp.data_rdata = 32'h333;
        cycle();
        chk("il_rsp3_cpu", 128'(s_cpu.data_rvalid), 128'(1));
        cache_rsp.data_rvalid = 1'b0;
        cycle();
        chk("il_no_err", 128'(s_err), 128'(0));

        // Prefetch enable drops one cycle after a PF grant.
        reset_dut();
        cache_rsp.data_gnt = 1'b1;
        pf_req.data_req = 1'b1;  pf_req.address_index = 12'h005;  pf_en = 1'b1;
        cycle();
        chk("pfd_gnt", 128'(s_pf.data_gnt), 128'(1));
        pf_en = 1'b0;  pf_req.address_index = 12'h006;
        pf_req.tag_valid = 1'b1;  pf_req.address_tag = 20'h000F5;
        cycle();
        chk("pfd_tag_valid", 128'(s_cache.tag_valid), 128'(1));
        chk("pfd_tag", 128'(s_cache.address_tag), 128'(20'h000F5));
        chk("pfd_no_req", 128'(s_cache.data_req), 128'(0));
        pf_req.tag_valid = 1'b0;  cache_rsp.data_rvalid = 1'b1;  cache_rsp.data_rdata = 32'h55;
        cycle();
        chk("pfd_rvalid", 128'(s_pf.data_rvalid), 128'(1));
        cache_rsp.data_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("pfd_no_gnt", 128'(s_pf.data_gnt), 128'(0));
        end
        chk("pfd_cnt", 128'(s_cnt), 128'(1));

        // Spurious response with an empty FIFO.
        reset_dut();
        cache_rsp.data_rvalid = 1'b1;  cache_rsp.data_rdata = 32'h77;
        cycle();
        chk("sp_cpu_rv", 128'(s_cpu.data_rvalid), 128'(0));
        chk("sp_pf_rv", 128'(s_pf.data_rvalid), 128'(0));
        cache_rsp.data_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("sp_err_sticky", 128'(s_err), 128'(1));
        end
        reset_dut();
        cycle();
        chk("sp_err_cleared", 128'(s_err), 128'(0));

        // Randomized traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            cpu_req = rand_req(60);
            pf_req  = rand_req(50);
            pf_en   = ($urandom_range(9, 0) != 0);
            cache_rsp.data_gnt    = ($urandom_range(4, 0) != 0);
            cache_rsp.data_rvalid = (m_q.size() > 0) && ($urandom_range(1, 0) == 1);
            cache_rsp.data_rdata  = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
